// File: rtl/div_unit_pkg.sv
// Shared definitions for the divider: FSM state encodings and the
// DIV/DIVU function-field constants used by the decoder.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // MIPS SPECIAL funct codes for the two divide instructions.
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only if it did not
// go negative. The kept remainder is always below the divisor, so it fits
// in WIDTH bits.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] diff;

  // Trial subtraction; a clear borrow bit means the divisor fitted.
  always_comb begin
    diff     = partial - {1'b0, divisor};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. Works on operand magnitudes
// and applies the sign fix-up when the last quotient bit is produced.
//
// Handshake: start is a request sampled only in DivFree; the operands and
// signed_div are captured on that accepting edge and may change afterwards.
// ready is a one-cycle completion strobe (result is valid from then until
// the next completion or reset). There is no back-pressure on ready; a
// start held high through DivEnd is taken on the following DivFree cycle.
// annul aborts in every state and beats start.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall,
  output div_state_e         dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state, next_state;

  logic [CW-1:0]  cnt;
  // rem holds the already-shifted partial remainder fed to the next step;
  // quo holds the unconsumed dividend bits on top, quotient bits enter at
  // the LSB.
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fin_q;

  assign dbg_state = state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial  (rem),
    .divisor  (dsor),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // Operand magnitudes; the most negative value maps onto its own bit
  // pattern, which is the correct unsigned magnitude.
  always_comb begin
    abs1  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    fin_q = {quo[WIDTH-2:0], step_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= DivFree;
    else         state <= next_state;
  end

  // Next-state, ready strobe and stall request.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    stall      = 1'b0;
    case (state)
      DivFree: begin
        if (start && !annul) begin
          stall      = 1'b1;
          next_state = (opdata2 == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        stall      = 1'b1;
        next_state = DivEnd;
      end
      DivOn: begin
        stall = 1'b1;
        if (cnt == LAST) next_state = DivEnd;
      end
      DivEnd: begin
        ready      = 1'b1;
        next_state = DivFree;
      end
      default: next_state = DivFree;
    endcase
    if (annul) begin
      next_state = DivFree;
      ready      = 1'b0;
    end
  end

  // Operand capture, iteration datapath and result load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dsor   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DivFree: begin
          if (start && !annul) begin
            cnt   <= '0;
            rem   <= {{WIDTH{1'b0}}, abs1[WIDTH-1]};
            quo   <= {abs1[WIDTH-2:0], 1'b0};
            dsor  <= abs2;
            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div & opdata1[WIDTH-1];
          end
        end
        DivByZero: begin
          if (!annul) result <= '0;
        end
        DivOn: begin
          if (!annul) begin
            cnt <= cnt + CW'(1);
            rem <= {step_rem, quo[WIDTH-1]};
            quo <= fin_q;
            if (cnt == LAST) begin
              result <= {neg_r ? -step_rem : step_rem,
                         neg_q ? -fin_q    : fin_q};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
